// File: rtl/rans_byte_packer.sv
// rANS renormalisation byte packer: compacts per-lane bytes into AXI-stream beats with tlast.
// Optional: define RANS_PACK_BYTE_COUNT_EN to add byte_count_o (bytes delivered in the current block).
module rans_byte_packer #(
    parameter int NUM_RANS  = 4,
    parameter int OUT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [NUM_RANS-1:0]    in_mask_i,
    input  logic [8*NUM_RANS-1:0]  in_data_i,
    input  logic                   in_last_i,
    output logic                   m_tvalid_o,
    input  logic                   m_tready_i,
    output logic [OUT_WIDTH-1:0]   m_tdata_o,
    output logic [OUT_WIDTH/8-1:0] m_tkeep_o,
    output logic                   m_tlast_o
`ifdef RANS_PACK_BYTE_COUNT_EN
    ,
    output logic [31:0]            byte_count_o
`endif
);
    localparam int OUT_BYTES = OUT_WIDTH / 8;
    localparam int CAP       = 2 * OUT_BYTES;
    localparam int CNT_W     = $clog2(CAP + 1);
    localparam logic [CNT_W-1:0] OUT_BYTES_C = CNT_W'(OUT_BYTES);
    localparam logic [CNT_W-1:0] READY_MAX_C = CNT_W'(CAP - NUM_RANS);

    logic [8*CAP-1:0]      acc;
    logic [8*CAP-1:0]      acc_shift;
    logic [8*CAP-1:0]      acc_nxt;
    logic [8*CAP-1:0]      append;
    logic [8*NUM_RANS-1:0] packed_in;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_s;
    logic [CNT_W-1:0]      count_nxt;
    logic [CNT_W-1:0]      pop_n;
    logic                  flush_pending;
    logic                  flush_nxt;
    logic                  accept;
    logic                  fire;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_RANS-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_RANS; k++) begin
            c = c + CNT_W'(m[k]);
        end
        return c;
    endfunction

    // Ready depends only on registered state, so no comb path from the output side.
    assign in_ready_o = !rst_i && !flush_pending && (count <= READY_MAX_C);
    assign m_tvalid_o = (count >= OUT_BYTES_C) || flush_pending;
    assign m_tlast_o  = flush_pending && (count <= OUT_BYTES_C);
    assign accept     = in_valid_i && in_ready_o;
    assign fire       = m_tvalid_o && m_tready_i;

    always_comb begin
        m_tkeep_o = '0;
        m_tdata_o = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            m_tkeep_o[i] = (CNT_W'(i) < count);
            m_tdata_o[8*i +: 8] = (CNT_W'(i) < count) ? acc[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        int pos;
        packed_in = '0;
        pos = 0;
        for (int k = 0; k < NUM_RANS; k++) begin
            if (in_mask_i[k]) begin
                packed_in[8*pos +: 8] = in_data_i[8*k +: 8];
                pos = pos + 1;
            end
        end
    end

    // Pop first, then append behind whatever remains.
    always_comb begin
        pop_n = '0;
        if (fire) begin
            pop_n = (count >= OUT_BYTES_C) ? OUT_BYTES_C : count;
        end
        count_s   = count - pop_n;
        acc_shift = acc >> {pop_n, 3'b000};
        for (int i = 0; i < CAP; i++) begin
            if (CNT_W'(i) >= count_s) begin
                acc_shift[8*i +: 8] = 8'h00;
            end
        end
        append    = {{(8*(CAP-NUM_RANS)){1'b0}}, packed_in} << {count_s, 3'b000};
        acc_nxt   = acc_shift;
        count_nxt = count_s;
        flush_nxt = flush_pending;
        if (fire && m_tlast_o) begin
            flush_nxt = 1'b0;
        end
        if (accept) begin
            acc_nxt   = acc_shift | append;
            count_nxt = count_s + popcount(in_mask_i);
            if (in_last_i) begin
                flush_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        acc <= acc_nxt;
        if (rst_i) begin
            count         <= '0;
            flush_pending <= 1'b0;
        end else begin
            count         <= count_nxt;
            flush_pending <= flush_nxt;
        end
    end

`ifdef RANS_PACK_BYTE_COUNT_EN
    logic        bc_clear;
    logic [31:0] bc_base;

    // After the tlast handshake the total is shown for one cycle, then restarts from 0.
    assign bc_base = bc_clear ? 32'd0 : byte_count_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_count_o <= 32'd0;
            bc_clear     <= 1'b0;
        end else begin
            bc_clear     <= fire && m_tlast_o;
            byte_count_o <= fire ? (bc_base + 32'(pop_n)) : bc_base;
        end
    end
`endif

endmodule
